// File: rtl/time_pulse_gen.sv
// time_pulse_gen: multi-channel programmable strobe generator with a
// seconds/frame timebase.
//
// Ports:
//   clk20mhz   - sole clock, all logic on the rising edge
//   rst_n      - asynchronous active-low reset
//   en         - count enable; counters and outputs hold while low
//   sync       - synchronous realign: clears counters, loads shadow config
//   cfg_we     - write strobe for the shadow config of channel cfg_ch
//   cfg_ch     - channel select for the config write
//   cfg_period - period in cycles (below 2 disables the channel)
//   cfg_on     - window start count (inclusive)
//   cfg_off    - window end count (exclusive)
//   strobe     - per-channel registered window output
//   tick_sec   - one-cycle pulse at each second boundary
//   pps        - second marker, PPS_W cycles wide
//   sec_cnt    - seconds within the current frame
//   min_pulse  - high for the whole second in which sec_cnt == 1
module time_pulse_gen #(
  parameter int unsigned CLK_HZ     = 20000000,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MIN_SEC    = 15,
  parameter int unsigned PPS_W      = 10000000,
  parameter int unsigned DEF_PERIOD = 20,
  parameter int unsigned DEF_ON     = 1,
  parameter int unsigned DEF_OFF    = 10,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned SC_W      = (MIN_SEC > 1) ? $clog2(MIN_SEC) : 1
) (
  input  logic             clk20mhz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_off,
  output logic [N_CH-1:0]  strobe,
  output logic             tick_sec,
  output logic             pps,
  output logic [SC_W-1:0]  sec_cnt,
  output logic             min_pulse
);

  localparam int unsigned SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
  } ch_cfg_t;

  localparam ch_cfg_t DEF_CFG = '{
    period: CNT_W'(DEF_PERIOD),
    on:     CNT_W'(DEF_ON),
    off:    CNT_W'(DEF_OFF)
  };

  ch_cfg_t wr_cfg;
  assign wr_cfg = '{period: cfg_period, on: cfg_on, off: cfg_off};

  // Strobe channels: each has an active config driving the counter and a
  // shadow that is written by software and promoted at wrap or sync.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_cfg_t          act;
    ch_cfg_t          shd;
    ch_cfg_t          shd_nxt;
    logic [CNT_W-1:0] cnt;
    logic             strb;
    logic             wr_sel;
    logic             wrap;
    logic             in_win;

    // shd_nxt already contains this cycle's write, so a write coinciding
    // with a wrap or sync takes effect for the period that starts next.
    always_comb begin
      wr_sel  = cfg_we && (32'(cfg_ch) == 32'(i));
      shd_nxt = wr_sel ? wr_cfg : shd;
      wrap    = (cnt == (act.period - CNT_W'(1)));
      in_win  = (cnt >= act.on) && (cnt < act.off);
    end

    always_ff @(posedge clk20mhz or negedge rst_n) begin
      if (!rst_n) begin
        act  <= DEF_CFG;
        shd  <= DEF_CFG;
        cnt  <= '0;
        strb <= 1'b0;
      end else begin
        shd <= shd_nxt;
        if (sync) begin
          act  <= shd_nxt;
          cnt  <= '0;
          strb <= 1'b0;
        end else if (act.period < CNT_W'(2)) begin
          // Disabled channel keeps tracking the shadow so a valid period
          // written later starts immediately.
          act  <= shd_nxt;
          cnt  <= '0;
          strb <= 1'b0;
        end else if (en) begin
          strb <= in_win;
          if (wrap) begin
            cnt <= '0;
            act <= shd_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end

    assign strobe[i] = strb;
  end

  // Seconds timebase.
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);

  logic [SEC_W-1:0] sec_ctr;
  logic             sec_wrap;
  logic             pps_win;
  logic [SC_W-1:0]  sec_cnt_nxt;

  always_comb begin
    sec_wrap    = (sec_ctr == SEC_LAST);
    pps_win     = (sec_ctr != '0) && (32'(sec_ctr) <= PPS_W);
    sec_cnt_nxt = sec_cnt;
    if (sync) begin
      sec_cnt_nxt = '0;
    end else if (en && sec_wrap) begin
      sec_cnt_nxt = (32'(sec_cnt) == (MIN_SEC - 1)) ? '0 : sec_cnt + SC_W'(1);
    end
  end

  // min_pulse is registered from the next sec_cnt so it lines up exactly
  // with the second in which sec_cnt reads 1.
  always_ff @(posedge clk20mhz or negedge rst_n) begin
    if (!rst_n) begin
      sec_ctr   <= '0;
      sec_cnt   <= '0;
      tick_sec  <= 1'b0;
      pps       <= 1'b0;
      min_pulse <= 1'b0;
    end else begin
      sec_cnt <= sec_cnt_nxt;
      if (sync) begin
        sec_ctr   <= '0;
        tick_sec  <= 1'b0;
        pps       <= 1'b0;
        min_pulse <= 1'b0;
      end else if (en) begin
        sec_ctr   <= sec_wrap ? '0 : sec_ctr + SEC_W'(1);
        tick_sec  <= sec_wrap;
        pps       <= pps_win;
        min_pulse <= (sec_cnt_nxt == SC_W'(1));
      end else begin
        tick_sec  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/time_pulse_gen.md
TIME_PULSE_GEN -- requirements
Module: time_pulse_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 20000000, clock cycles per second.
REQ-002 SHALL have parameter N_CH, default 4, number of independent strobe channels.
REQ-003 SHALL have parameter CNT_W, default 32, width of channel period/window counters.
REQ-004 SHALL have parameter MIN_SEC, default 15, seconds per "minute" frame.
REQ-005 SHALL have parameter PPS_W, default 10000000, cycles pps stays high after second boundary.
REQ-006 SHALL have parameters DEF_PERIOD/DEF_ON/DEF_OFF, defaults 20/1/10, reset config of every channel.
REQ-007 Ports:
  clk20mhz  in   1  sole clock, all logic rising-edge;
  rst_n     in   1  asynchronous, active-low reset;
  en        in   1  count enable, counters hold when 0;
  sync      in   1  synchronous realign pulse;
  cfg_we    in   1  config write strobe;
  cfg_ch    in   clog2(N_CH)  channel select;
  cfg_period in  CNT_W  period in cycles;
  cfg_on    in   CNT_W  window start count;
  cfg_off   in   CNT_W  window end count (exclusive);
  strobe    out  N_CH  per-channel registered window output;
  tick_sec  out  1  one-cycle pulse at each second boundary;
  pps       out  1  second-marker pulse, PPS_W cycles wide;
  sec_cnt   out  clog2(MIN_SEC)  seconds within frame;
  min_pulse out  1  high for whole second where sec_cnt==1.

Function
REQ-008 Each channel SHALL hold active (period,on,off) and shadow copies; cfg_we writes shadow of cfg_ch in one cycle; cfg_ch >= N_CH ignored.
REQ-009 Channel counter SHALL count 0..period-1 when en=1, wrap to 0; shadow copied to active on the cycle counter wraps to 0.
REQ-010 strobe[i] SHALL be registered: high in cycle after counter value c satisfies on <= c < off; latency exactly 1 cycle.
REQ-011 period < 2: channel disabled, counter held 0, strobe low, shadow loaded every cycle.
REQ-012 on >= off: strobe constantly low; off > period: strobe high from on through wrap cycle.
REQ-013 Second counter SHALL count 0..CLK_HZ-1 when en=1; tick_sec high one cycle when counter==CLK_HZ-1.
REQ-014 pps SHALL be high in cycle after second counter value s satisfies 0 < s <= PPS_W, else low.
REQ-015 sec_cnt SHALL increment on each tick_sec, wrap MIN_SEC-1 -> 0; min_pulse registered from sec_cnt==1.
REQ-016 en=0: all counters and outputs hold current values; tick_sec forced low.
REQ-017 sync=1 SHALL clear all channel, second and sec_cnt counters to 0 and load all shadows to active next edge; strobe, tick_sec, pps low that cycle; sync overrides en.
REQ-018 sync and cfg_we same cycle: write lands in shadow AND is loaded to active (write first, then load).
REQ-019 cfg_we on the exact wrap cycle of that channel: new value used for the starting period.
REQ-020 Arithmetic SHALL be unsigned, comparisons full CNT_W width, no truncation.

Reset
REQ-021 rst_n=0 SHALL immediately clear all counters, sec_cnt, strobe, tick_sec, pps, min_pulse to 0 and set active+shadow config to DEF_PERIOD/DEF_ON/DEF_OFF, regardless of clock.
REQ-022 After release, first counting edge SHALL move counters from 0 to 1; reset mid-window drops strobe asynchronously.

Verification
REQ-023 Defaults, en=1 after reset: strobe[0] high 9 cycles out of 20, rising 2 cycles after release, period 20 exactly.
REQ-024 cfg_we ch1 period=400,on=1,off=200 mid-period: old waveform completes, new 400-cycle/199-high waveform starts at next wrap.
REQ-025 CLK_HZ=100, PPS_W=10, MIN_SEC=3: tick_sec every 100 cycles, pps 10 cycles wide, sec_cnt 0,1,2,0, min_pulse high 100 cycles per 300.
REQ-026 sync asserted at arbitrary count: all counters 0 next edge, all strobes realigned phase-identical to post-reset.
REQ-027 Boundaries: period=1 -> strobe low; on=5,off=5 -> low; off=30,period=20 -> high counts 1..19 and wrap; en=0 freezes strobe level.
REQ-028 rst_n pulsed low mid-window with no clock edge: outputs 0 immediately, config back to 20/1/10.
